// File: rtl/rr_arb_enc_pkg.sv
// rr_arb_enc_pkg: shared definitions for the round-robin arbiter.
//   - arb_state_t      : arbiter state encoding (ARB_IDLE / ARB_GRANT)
//   - DEFAULT_MAX_HOLD : default forced-release limit (used with ARB_TIMEOUT_EN)
//   - clog2()          : ceiling log2 for elaboration-time widths
package rr_arb_enc_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned DEFAULT_MAX_HOLD = 255;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating priority encoder.
// Scans req starting at bit ptr, ascending, wrapping from N-1 to 0; first set bit wins.
// Ports:
//   req        in  N     request vector
//   ptr        in  IDXW  highest-priority position (must be < N)
//   any        out 1     at least one request present
//   win_onehot out N     one-hot winner, zero when any=0
//   win_idx    out IDXW  binary winner index, zero when any=0
module rr_pick
    import rr_arb_enc_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned IDXW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic            any,
    output logic [N-1:0]    win_onehot,
    output logic [IDXW-1:0] win_idx
);

    int unsigned     pos;
    logic [IDXW-1:0] pos_idx;

    always_comb begin
        any        = 1'b0;
        win_onehot = '0;
        win_idx    = '0;
        pos        = 0;
        pos_idx    = '0;
        for (int i = 0; i < int'(N); i++) begin
            // Position i steps after ptr, folded back into 0..N-1.
            pos = 32'(ptr) + 32'(i);
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IDXW'(pos);
            if (!any && req[pos_idx]) begin
                any                 = 1'b1;
                win_onehot[pos_idx] = 1'b1;
                win_idx             = pos_idx;
            end
        end
    end

endmodule

// File: rtl/rr_arb_enc.sv
// rr_arb_enc: round-robin arbiter with registered one-hot and encoded grant.
// A grant is held until done; on release priority rotates to the requester after
// the last owner and a new winner is taken in the same cycle (no bubble).
// Optional macro ARB_TIMEOUT_EN: force-release a grant held for MAX_HOLD cycles and
// pulse timeout; without it timeout is tied to 0.
// Ports:
//   clk        in  1     system clock, rising edge
//   reset      in  1     asynchronous active-high reset
//   req        in  N     request vector
//   done       in  1     owner's completion pulse, releases the grant
//   gnt_valid  out 1     a grant is held
//   gnt_onehot out N     registered one-hot grant, zero when idle
//   gnt_idx    out IDXW  registered grant index, zero when idle
//   timeout    out 1     one-cycle pulse on forced release
module rr_arb_enc
    import rr_arb_enc_pkg::*;
#(
    parameter int unsigned N        = 16,
    parameter int unsigned IDXW     = clog2(N),
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic            gnt_valid,
    output logic [N-1:0]    gnt_onehot,
    output logic [IDXW-1:0] gnt_idx,
    output logic            timeout
);

    arb_state_t      state_q;
    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] rel_ptr;
    logic [IDXW-1:0] pick_ptr;
    logic            force_rel;
    logic            release_now;
    logic            pick_any;
    logic [N-1:0]    pick_onehot;
    logic [IDXW-1:0] pick_idx;

    assign release_now = (state_q == ARB_GRANT) && (done || force_rel);
    assign rel_ptr     = (gnt_idx == IDXW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    // On release the next pick already uses the rotated pointer.
    assign pick_ptr    = release_now ? rel_ptr : ptr_q;

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req        (req),
        .ptr        (pick_ptr),
        .any        (pick_any),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= '0;
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            gnt_idx    <= '0;
        end else begin
            if (release_now) begin
                ptr_q <= rel_ptr;
            end
            if ((state_q == ARB_IDLE) || release_now) begin
                if (pick_any) begin
                    state_q    <= ARB_GRANT;
                    gnt_valid  <= 1'b1;
                    gnt_onehot <= pick_onehot;
                    gnt_idx    <= pick_idx;
                end else begin
                    state_q    <= ARB_IDLE;
                    gnt_valid  <= 1'b0;
                    gnt_onehot <= '0;
                    gnt_idx    <= '0;
                end
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HOLDW = clog2(MAX_HOLD + 1);

    logic [HOLDW-1:0] hold_cnt;
    logic             new_grant;

    assign new_grant = pick_any && ((state_q == ARB_IDLE) || release_now);
    // Hit one count early so the last held cycle is cycle MAX_HOLD of the grant.
    assign force_rel = (state_q == ARB_GRANT) && (hold_cnt == HOLDW'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= force_rel;
            if (new_grant) begin
                hold_cnt <= '0;
            end else if ((state_q == ARB_GRANT) && !done) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_max_hold;

    assign force_rel       = 1'b0;
    assign timeout         = 1'b0;
    assign unused_max_hold = ^MAX_HOLD;
`endif

endmodule

// File: tb/tb_rr_arb_enc.sv
// tb_rr_arb_enc: directed self-checking bench for rr_arb_enc (N=16, MAX_HOLD=4).
module tb_rr_arb_enc;

    logic        clk;
    logic        reset;
    logic [15:0] req;
    logic        done;
    logic        gnt_valid;
    logic [15:0] gnt_onehot;
    logic [3:0]  gnt_idx;
    logic        timeout;

    int n_checks;
    int n_fail;

    rr_arb_enc #(
        .N        (16),
        .MAX_HOLD (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .done       (done),
        .gnt_valid  (gnt_valid),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_gnt(input string tag, input logic v, input int idx);
        logic [15:0] exp_oh;
        logic [3:0]  exp_idx;
        exp_oh  = v ? (16'h0001 << idx) : 16'h0000;
        exp_idx = v ? 4'(idx) : 4'd0;
        check({tag, " valid"}, 64'(gnt_valid), 64'(v));
        check({tag, " idx"}, 64'(gnt_idx), 64'(exp_idx));
        check({tag, " onehot"}, 64'(gnt_onehot), 64'(exp_oh));
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        req      = 16'h0000;
        done     = 1'b0;
        tick();
        check_gnt("reset", 1'b0, 0);
        check("reset timeout", 64'(timeout), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            check_gnt("idle no req", 1'b0, 0);
        end

        // Basic grant, back-to-back handover, release to idle.
        req = 16'h0090;
        tick();
        check_gnt("first grant", 1'b1, 4);
        pulse_done();
        check_gnt("handover", 1'b1, 7);
        req = 16'h0000;
        pulse_done();
        check_gnt("release idle", 1'b0, 0);

        // Full rotation with all requesting.
        do_reset();
        req = 16'hFFFF;
        tick();
        check_gnt("rot start", 1'b1, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_gnt("rot hold", 1'b1, (k - 1) % 16);
            pulse_done();
            check_gnt("rot next", 1'b1, k % 16);
        end

        // Pointer wrap and sole-requester re-grant.
        do_reset();
        req = 16'h8000;
        tick();
        check_gnt("wrap owner", 1'b1, 15);
        req = 16'h8001;
        pulse_done();
        check_gnt("wrap to 0", 1'b1, 0);
        req = 16'h0001;
        pulse_done();
        check_gnt("sole regrant", 1'b1, 0);

        // done in idle is ignored.
        do_reset();
        req = 16'h0000;
        pulse_done();
        check_gnt("done in idle", 1'b0, 0);

        // Grant held regardless of req, then asynchronous reset mid-grant.
        req = 16'h0008;
        tick();
        check_gnt("hold owner", 1'b1, 3);
        req = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_gnt("hold ignores req", 1'b1, 3);
        end
        #2;
        reset = 1'b1;
        #1;
        check_gnt("async reset", 1'b0, 0);
        tick();
        check_gnt("reset held", 1'b0, 0);
        reset = 1'b0;
        tick();
        check_gnt("after reset", 1'b1, 5);

        // Never-done owner: forced release only with the timeout feature.
        do_reset();
        req = 16'h0003;
`ifdef ARB_TIMEOUT_EN
        for (int g = 0; g < 3; g++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                check_gnt("to grant", 1'b1, g % 2);
                check("to pulse", 64'(timeout), (c == 0 && g != 0) ? 64'd1 : 64'd0);
            end
        end
`else
        for (int c = 0; c < 300; c++) begin
            tick();
            check_gnt("no to hold", 1'b1, 0);
            check("no to pulse", 64'(timeout), 64'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arb_enc.md
Name: rr_arb_enc

Overview:
- Parametrised round-robin arbiter with an encoded grant output; the sequential successor to the fixed 16-to-4 encoder.
- Takes N request lines (e.g. cache/uncached/TLB-refill masters onto one AXI read port) and registers a one-hot grant plus its binary index.
- Holds each grant until the owner signals completion, then rotates priority to the requester after the last owner.

Parameters:
- N, 16, number of requesters; legal range 2..64.
- IDXW, $clog2(N), width of the encoded grant index.
- MAX_HOLD, 255, cycles a grant may be held before forced release; only used when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  request vector; bit i high means requester i wants the port.
- done  in  1  single-cycle pulse from the current owner: transaction complete, release grant.
- gnt_valid  out  1  a grant is currently held.
- gnt_onehot  out  N  one-hot grant, registered; all zero when gnt_valid=0.
- gnt_idx  out  IDXW  binary index of the granted requester, registered; 0 when gnt_valid=0.
- timeout  out  1  one-cycle pulse when a grant is force-released; tied to 0 unless ARB_TIMEOUT_EN is defined.

Behaviour:
- Reset (asynchronous, any cycle, including mid-grant):
  - gnt_valid=0, gnt_onehot=0, gnt_idx=0, timeout=0.
  - Priority pointer ptr=0, so requester 0 has highest priority.
  - State=IDLE. The in-progress grant is dropped with no done required.
- States:
  - IDLE: no grant held.
  - GRANT: gnt_valid=1. gnt_onehot and gnt_idx are stable for the whole state.
- Pick function:
  - Scan req starting at bit ptr, ascending, wrapping from N-1 to 0.
  - The first set bit wins.
  - If req=0, there is no winner.
- IDLE -> GRANT: on any cycle where req != 0, register the winner; outputs are valid the next cycle. Latency is 1 cycle from req to gnt_valid.
- In GRANT:
  - req changes are ignored. The grant is held even if the owner's req drops; only done releases it.
- GRANT, done=1:
  - ptr <= (gnt_idx+1) mod N.
  - The pick is evaluated in the same cycle using the new ptr against the current req.
  - Winner exists: stay in GRANT with the new grant (back-to-back, zero bubble).
  - No winner: go to IDLE.
  - The previous owner can win again only if it is the sole requester.
- done while in IDLE is ignored.
- ptr wraps: gnt_idx=N-1 with done gives ptr=0.
- gnt_onehot and gnt_idx always agree: gnt_onehot == (1 << gnt_idx) while gnt_valid=1.
- N not a power of 2: index values >= N never occur; the pick ignores nonexistent bits.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter (width clog2(MAX_HOLD+1)) clears on every new grant and increments each GRANT cycle without done.
  - When it reaches MAX_HOLD, the arbiter releases exactly as if done were seen and pulses timeout=1 for one cycle.
  - done and timeout in the same cycle count as a single release; timeout is still pulsed.
- Not defined: no counter logic; timeout is tied to 0.

Decomposition:
- Shared package/header:
  - State encoding constants ARB_IDLE=1'b0, ARB_GRANT=1'b1.
  - Default MAX_HOLD.
  - A clog2 helper function for IDXW.
- Sub-module rr_pick: purely combinational masked priority encoder.
  - Inputs: req[N], ptr[IDXW].
  - Outputs: any, win_onehot[N], win_idx[IDXW].
  - Implemented as a double-width (req,req) scan, or masked/unmasked dual priority encode.
- Top level: state register, ptr, output registers, timeout counter.

Test Plan:
- Reset, then req=16'h0000 for 5 cycles -> gnt_valid=0, gnt_onehot=0, gnt_idx=0 throughout.
- req=16'h0090 in IDLE with ptr=0 -> next cycle gnt_idx=4, gnt_onehot=16'h0010. Pulse done -> next cycle gnt_idx=7 (no bubble). Pulse done with req=0 -> IDLE.
- req=16'hFFFF held, done pulsed every 2nd cycle -> gnt_idx sequence 0,1,2,...,15,0; each index granted once per 16 grants.
- Grant idx=15 held, req=16'h8001, done -> ptr wraps to 0, next gnt_idx=0. Then done with req=16'h0001 -> idx 0 re-granted (sole requester).
- Grant idx=3 held, drop req[3] and raise req[5] -> grant stays at idx 3 until done. Assert reset mid-grant -> outputs 0 asynchronously; after release, req=16'h0020 gives gnt_idx=5 one cycle later.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=16'h0003, never done:
  - Expected grant sequence: idx0 for 4 cycles, timeout pulse, then idx1 for 4 cycles, timeout pulse.
  - With the macro undefined, the same stimulus holds idx0 indefinitely and timeout stays 0.
